// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Load/store initiator sitting between the pipeline MEM stage and a data RAM
//   with one read port and one write port. It takes one request at a time over
//   a valid/ready handshake.
//
//   - Word stores are written straight through.
//   - Byte and half stores read the containing word, merge the new lane in,
//     and then write the whole word back.
//   - Loads return sign- or zero-extended data with a one-cycle response pulse.
//   - Misaligned or illegal-size requests are answered with rsp_err_o and never
//     touch the RAM.
//
// Ports
//   clk_100MHz, arst                  clock (rising edge); async active-high reset
//   req_valid_i / req_ready_o         request handshake
//   req_we_i                          request type: 1 store, 0 load
//   req_size_i                        access size: 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i                    load extension: 1 zero, 0 sign
//   req_addr_i                        byte address
//   req_wdata_i                       right-aligned store data
//   rsp_valid_o, rsp_rdata_o,         completion pulse, load data and
//   rsp_err_o                         error flag
//   r_ena_o, r_addr_o, r_data_i       RAM read port (combinational read data)
//   w_ena_o, w_addr_o, w_data_o       RAM write port (commits on the next clock edge)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] GUARD_XOR = 32'h4
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              r_ena_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [31:0]       r_data_i,
    output logic              w_ena_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [31:0]       w_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word_q;   // store data at accept, merged word after RMW_RD
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              acc_err;
    logic [ADDR_W-1:0] addr_aligned;

    // Extract and extend the addressed lane of a read word.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                             input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{~uns & b[7]}}, b};
            2'b01:   res = {{16{~uns & h[15]}}, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half lane of a read word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] rd,
                                                input logic [31:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  a);
        logic [31:0] m;
        m = rd;
        case (size)
            2'b00:   m[{a, 3'b000} +: 8]     = wd[7:0];
            2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    assign acc_err = (req_size_i == 2'b11)
                   | ((req_size_i == 2'b01) & req_addr_i[0])
                   | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));

    assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        addr_q  <= req_addr_i;
                        word_q  <= req_wdata_i;
                        rdata_q <= '0;
                        err_q   <= acc_err;
                        if (acc_err)
                            state <= S_RESP;
                        else if (!req_we_i)
                            state <= S_RD;
                        else if (req_size_i == 2'b10)
                            state <= S_WR;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_RD: begin
                    rdata_q <= fmt_load(r_data_i, size_q, uns_q, addr_q[1:0]);
                    state   <= S_RESP;
                end
                S_RMW_RD: begin
                    word_q <= merge_store(r_data_i, word_q, size_q, addr_q[1:0]);
                    state  <= S_WR;
                end
                S_WR: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state; every one of them is forced low while arst is
    // asserted, so the RAM sees no activity during reset.
    always_comb begin
        req_ready_o = ~arst & (state == S_IDLE);
        r_ena_o     = ~arst & ((state == S_RD) | (state == S_RMW_RD));
        w_ena_o     = ~arst & (state == S_WR);
        rsp_valid_o = ~arst & (state == S_RESP);
        r_addr_o    = arst ? '0 : addr_aligned;
        // The RAM forwards w_data whenever the two addresses match, even with
        // the write disabled, so an idle write address is pushed to another word.
        if (arst)
            w_addr_o = '0;
        else if (state == S_WR)
            w_addr_o = addr_aligned;
        else
            w_addr_o = addr_aligned ^ GUARD_XOR[ADDR_W-1:0];
        w_data_o    = (~arst & (state == S_WR)) ? word_q : 32'h0;
        rsp_err_o   = ~arst & (state == S_RESP) & err_q;
        rsp_rdata_o = (~arst & (state == S_RESP) & ~we_q & ~err_q) ? rdata_q : 32'h0;
    end

endmodule
